// File: rtl/axis_pkg.sv
// Shared types and helpers for the AXI-Stream header strip datapath.
package axis_pkg;

  // Widest tkeep the mask helper supports; modules slice down to their own width.
  localparam int unsigned AXIS_KW_MAX = 64;

  typedef enum logic {
    HDR,
    PASS
  } strip_state_t;

  function automatic logic [AXIS_KW_MAX-1:0] keep_lo_mask(input int unsigned n);
    logic [AXIS_KW_MAX-1:0] m;
    for (int unsigned i = 0; i < AXIS_KW_MAX; i++) begin
      m[i] = (i < n);
    end
    return m;
  endfunction

endpackage

// File: rtl/axis_if.sv
// AXI-Stream bundle (tvalid/tready/tdata/tkeep/tlast) with master and slave views.
interface axis_if #(
  parameter int DW = 64,
  parameter int KW = ((DW - 1) >> 3) + 1
);
  logic          tvalid;
  logic          tready;
  logic [DW-1:0] tdata;
  logic [KW-1:0] tkeep;
  logic          tlast;

  modport master (output tvalid, tdata, tkeep, tlast, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, output tready);
endinterface

// File: rtl/axis_reg_slice.sv
// Single output register stage for an AXI-Stream beat; full throughput, ready
// looks only at the register occupancy and the downstream ready.
module axis_reg_slice #(
  parameter int AXIS_DW = 64,
  parameter int AXIS_KW = ((AXIS_DW - 1) >> 3) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [AXIS_DW-1:0] in_data,
  input  logic [AXIS_KW-1:0] in_keep,
  input  logic               in_last,
  output logic               in_ready,
  axis_if.master             m_axis
);

  logic               valid_q, valid_d;
  logic [AXIS_DW-1:0] data_q,  data_d;
  logic [AXIS_KW-1:0] keep_q,  keep_d;
  logic               last_q,  last_d;

  assign in_ready = !valid_q || m_axis.tready;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    keep_d  = keep_q;
    last_d  = last_q;
    if (in_ready) begin
      valid_d = in_valid;
      if (in_valid) begin
        data_d = in_data;
        keep_d = in_keep;
        last_d = in_last;
      end
    end
  end

  // NOTE: the data/keep/last registers are reset as well, because their reset value is visible on the port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
    end
  end

  assign m_axis.tvalid = valid_q;
  assign m_axis.tdata  = data_q;
  assign m_axis.tkeep  = keep_q;
  assign m_axis.tlast  = last_q;

endmodule

// File: rtl/axis_hdr_strip.sv
// Strips a programmable number of leading bytes from each AXI-Stream packet.
// Optional runt reporting (runt_pulse/runt_cnt) is built when AXIS_HDR_STRIP_RUNT_EN is defined.
module axis_hdr_strip
  import axis_pkg::*;
#(
  parameter int AXIS_DW = 64,
  parameter int AXIS_KW = ((AXIS_DW - 1) >> 3) + 1,
  parameter int HLEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [HLEN_W-1:0] hdr_len,
  axis_if.slave             s_axis,
  axis_if.master            m_axis
`ifdef AXIS_HDR_STRIP_RUNT_EN
  ,
  output logic              runt_pulse,
  output logic [15:0]       runt_cnt
`endif
);

  localparam logic [HLEN_W-1:0] KW_LEN = HLEN_W'(AXIS_KW);

  strip_state_t          state_q, state_d;
  logic                  first_q, first_d;
  logic [HLEN_W-1:0]     rem_q,   rem_d;

  logic                  in_ready;
  logic                  accept;
  logic                  hdr_beat;
  logic                  runt;
  logic                  fwd_valid;
  logic [HLEN_W-1:0]     eff_rem;
  logic [HLEN_W-1:0]     kept_cnt;
  logic [AXIS_KW_MAX-1:0] mask_full;
  logic [AXIS_KW-1:0]    strip_mask;
  logic [AXIS_KW-1:0]    out_keep;
  logic [AXIS_DW-1:0]    out_data;

  assign s_axis.tready = in_ready;
  assign accept        = s_axis.tvalid && in_ready;

  always_comb begin
    eff_rem = first_q ? hdr_len : ((state_q == PASS) ? '0 : rem_q);

    kept_cnt = '0;
    for (int i = 0; i < AXIS_KW; i++) begin
      kept_cnt = kept_cnt + HLEN_W'(s_axis.tkeep[i]);
    end

    // A tlast beat with nothing left after stripping means no earlier beat was forwarded either.
    hdr_beat  = (eff_rem >= KW_LEN);
    runt      = s_axis.tlast && (kept_cnt <= eff_rem);
    fwd_valid = s_axis.tvalid && !hdr_beat && !runt;

    mask_full  = keep_lo_mask(32'(eff_rem));
    strip_mask = mask_full[AXIS_KW-1:0];
    out_keep   = s_axis.tkeep & ~strip_mask;
    for (int b = 0; b < AXIS_KW; b++) begin
      out_data[8*b +: 8] = strip_mask[b] ? 8'h00 : s_axis.tdata[8*b +: 8];
    end
  end

  if (AXIS_KW < AXIS_KW_MAX) begin : g_mask_hi
    logic unused_mask_hi;
    assign unused_mask_hi = ^mask_full[AXIS_KW_MAX-1:AXIS_KW];
  end

  always_comb begin
    state_d = state_q;
    first_d = first_q;
    rem_d   = rem_q;
    if (accept) begin
      first_d = s_axis.tlast;
      if (s_axis.tlast) begin
        state_d = HDR;
        rem_d   = '0;
      end else if (hdr_beat) begin
        state_d = HDR;
        rem_d   = eff_rem - KW_LEN;
      end else begin
        state_d = PASS;
        rem_d   = '0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HDR;
      first_q <= 1'b1;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
      rem_q   <= rem_d;
    end
  end

  axis_reg_slice #(
    .AXIS_DW (AXIS_DW),
    .AXIS_KW (AXIS_KW)
  ) u_out_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (fwd_valid),
    .in_data  (out_data),
    .in_keep  (out_keep),
    .in_last  (s_axis.tlast),
    .in_ready (in_ready),
    .m_axis   (m_axis)
  );

`ifdef AXIS_HDR_STRIP_RUNT_EN
  logic        runt_pulse_q, runt_pulse_d;
  logic [15:0] runt_cnt_q,   runt_cnt_d;

  always_comb begin
    runt_pulse_d = accept && runt;
    runt_cnt_d   = runt_cnt_q;
    if (runt_pulse_d && (runt_cnt_q != 16'hFFFF)) begin
      runt_cnt_d = runt_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      runt_pulse_q <= 1'b0;
      runt_cnt_q   <= '0;
    end else begin
      runt_pulse_q <= runt_pulse_d;
      runt_cnt_q   <= runt_cnt_d;
    end
  end

  assign runt_pulse = runt_pulse_q;
  assign runt_cnt   = runt_cnt_q;
`endif

endmodule

// File: tb/tb_axis_hdr_strip.sv
// Self-checking bench for axis_hdr_strip: directed cases plus randomized packets
// checked against a byte-position reference model.
module tb_axis_hdr_strip;

  localparam int DW = 64;
  localparam int KW = 8;
  localparam int HW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [HW-1:0] hdr_len;

  axis_if #(.DW(DW), .KW(KW)) s_if ();
  axis_if #(.DW(DW), .KW(KW)) m_if ();

`ifdef AXIS_HDR_STRIP_RUNT_EN
  logic        runt_pulse;
  logic [15:0] runt_cnt;
`endif

  always #5 clk = ~clk;

  axis_hdr_strip #(
    .AXIS_DW (DW),
    .AXIS_KW (KW),
    .HLEN_W  (HW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .hdr_len    (hdr_len),
    .s_axis     (s_if),
    .m_axis     (m_if)
`ifdef AXIS_HDR_STRIP_RUNT_EN
    ,
    .runt_pulse (runt_pulse),
    .runt_cnt   (runt_cnt)
`endif
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  int    checks    = 0;
  int    failures  = 0;
  beat_t exp_q[$];
  int    ready_mode = 0;   // 0: always ready, 1: random, 2: stalled
  int    m_pos      = 0;
  int    m_h        = 0;
  bit    m_first    = 1'b1;
  int    exp_runts  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: byte p of a packet survives iff p >= header length and its keep bit is set.
  task automatic model_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
    logic [KW-1:0] surv;
    logic [DW-1:0] od;
    if (m_first) begin
      m_h     = int'(hdr_len);
      m_pos   = 0;
      m_first = 1'b0;
    end
    surv = '0;
    od   = d;
    for (int j = 0; j < KW; j++) begin
      if (m_pos + j < m_h) od[8*j +: 8] = 8'h00;
      else if (k[j])       surv[j] = 1'b1;
    end
    if (surv != '0) exp_q.push_back('{data: od, keep: surv, last: l});
    m_pos += KW;
    if (l) begin
      if (surv == '0) exp_runts++;
      m_first = 1'b1;
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the beat was accepted.
  task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
    int waited = 0;
    s_if.tvalid = 1'b1;
    s_if.tdata  = d;
    s_if.tkeep  = k;
    s_if.tlast  = l;
    #1;
    while (s_if.tready !== 1'b1 && waited < 200) begin
      @(negedge clk);
      #1;
      waited++;
    end
    check("s_ready_wait", 64'(waited < 200), 64'd1);
    model_beat(d, k, l);
    @(negedge clk);
    s_if.tvalid = 1'b0;
    s_if.tkeep  = '0;
    s_if.tlast  = 1'b0;
  endtask

  task automatic send_rand_pkt(input bit vary_hdr);
    int          n;
    int          nb;
    logic [8:0]  t;
    logic [KW-1:0] k;
    n = $urandom_range(1, 4);
    for (int i = 0; i < n; i++) begin
      k = '1;
      if (i == n - 1) begin
        nb = $urandom_range(1, KW);
        t  = (9'd1 << nb) - 9'd1;
        k  = t[KW-1:0];
      end
      if (vary_hdr && $urandom_range(0, 2) == 0) hdr_len = HW'($urandom_range(0, 20));
      send_beat({$urandom, $urandom}, k, i == n - 1);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
  endtask

  task automatic drain(input string tag);
    int w = 0;
    while (exp_q.size() != 0 && w < 500) begin
      @(negedge clk);
      w++;
    end
    check(tag, 64'(exp_q.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    m_if.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       m_if.tready = 1'b1;
        1:       m_if.tready = 1'($urandom_range(0, 1));
        default: m_if.tready = 1'b0;
      endcase
    end
  end

  always @(negedge clk) begin
    beat_t b;
    if (rst_n === 1'b1 && m_if.tvalid === 1'b1 && m_if.tready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("extra_out_beat", 64'(exp_q.size()), 64'd1);
      end else begin
        b = exp_q.pop_front();
        check("out_tdata", m_if.tdata, b.data);
        check("out_tkeep", 64'(m_if.tkeep), 64'(b.keep));
        check("out_tlast", 64'(m_if.tlast), 64'(b.last));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] d;

    rst_n       = 1'b0;
    hdr_len     = '0;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tkeep  = '0;
    s_if.tlast  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_m_valid", 64'(m_if.tvalid), 64'd0);
    check("rst_m_tdata", m_if.tdata, 64'd0);
    check("rst_m_tkeep", 64'(m_if.tkeep), 64'd0);
    check("rst_m_tlast", 64'(m_if.tlast), 64'd0);
`ifdef AXIS_HDR_STRIP_RUNT_EN
    check("rst_runt_cnt", 64'(runt_cnt), 64'd0);
    check("rst_runt_pulse", 64'(runt_pulse), 64'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Header of 3 bytes inside a 2-beat packet.
    hdr_len = 16'd3;
    send_beat(64'h0807_0605_0403_0201, 8'hFF, 1'b0);
    send_beat(64'h100F_0E0D_0C0B_0A09, 8'h0F, 1'b1);
    drain("drain_hdr3");

    // Header of exactly one beat; the remaining beats stream with no bubble.
    hdr_len = 16'd8;
    send_beat({$urandom, $urandom}, 8'hFF, 1'b0);
    send_beat({$urandom, $urandom}, 8'hFF, 1'b0);
    send_beat({$urandom, $urandom}, 8'h03, 1'b1);
    #1;
    check("nobubble_valid", 64'(m_if.tvalid), 64'd1);
    check("nobubble_keep", 64'(m_if.tkeep), 64'h03);
    check("nobubble_last", 64'(m_if.tlast), 64'd1);
    drain("drain_hdr8");

    // Runt: every kept byte lies within the header.
    hdr_len = 16'd12;
    send_beat({$urandom, $urandom}, 8'hFF, 1'b0);
    send_beat({$urandom, $urandom}, 8'h0F, 1'b1);
    #1;
    check("runt_no_out", 64'(m_if.tvalid), 64'd0);
`ifdef AXIS_HDR_STRIP_RUNT_EN
    check("runt_pulse_hi", 64'(runt_pulse), 64'd1);
    check("runt_cnt_1", 64'(runt_cnt), 64'(exp_runts));
    @(negedge clk);
    #1;
    check("runt_pulse_lo", 64'(runt_pulse), 64'd0);
`endif
    drain("drain_runt");

    // Zero header: one-cycle latency, bit-exact.
    hdr_len = 16'd0;
    d = {$urandom, $urandom};
    send_beat(d, 8'hFF, 1'b1);
    #1;
    check("lat_valid", 64'(m_if.tvalid), 64'd1);
    check("lat_data", m_if.tdata, d);
    drain("drain_lat");

    // Downstream stall mid-packet: input blocked, output held.
    hdr_len    = 16'd5;
    ready_mode = 2;
    send_beat({$urandom, $urandom}, 8'hFF, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall_s_ready", 64'(s_if.tready), 64'd0);
      check("stall_m_valid", 64'(m_if.tvalid), 64'd1);
      check("stall_m_data", m_if.tdata, exp_q[0].data);
      @(negedge clk);
    end
    ready_mode = 0;
    send_beat({$urandom, $urandom}, 8'hFF, 1'b0);
    send_beat({$urandom, $urandom}, 8'h07, 1'b1);
    drain("drain_stall");

    // Random pass-through stream with random backpressure.
    hdr_len    = 16'd0;
    ready_mode = 1;
    for (int p = 0; p < 10; p++) send_rand_pkt(1'b0);
    drain("drain_rand_pass");

    // Random header lengths, including changes in the middle of packets.
    for (int p = 0; p < 30; p++) begin
      hdr_len = HW'($urandom_range(0, 20));
      send_rand_pkt(1'b1);
    end
    drain("drain_rand_hdr");
`ifdef AXIS_HDR_STRIP_RUNT_EN
    check("rand_runt_cnt", 64'(runt_cnt), 64'(exp_runts));
`endif

    // Reset in the middle of a packet discards the held beat and restarts framing.
    ready_mode = 2;
    hdr_len    = 16'd3;
    send_beat({$urandom, $urandom}, 8'hFF, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_m_valid", 64'(m_if.tvalid), 64'd0);
    exp_q.delete();
    m_first   = 1'b1;
    exp_runts = 0;
    ready_mode = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_beat(64'h1122_3344_5566_7788, 8'hFF, 1'b0);
    #1;
    check("midrst_first_keep", 64'(m_if.tkeep), 64'hF8);
    @(negedge clk);
    send_beat({$urandom, $urandom}, 8'h0F, 1'b1);
    drain("drain_midrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
